note_player: RTL
================

// Module: note_player
// PURPOSE
//  Parametrised successor to the fixed single-note dividers: one block plays any of 12
//  semitones over 4 octaves for a programmed duration in ms, then reports completion.
//  Sits between the melody sequencer (start/ready handshake) and the buzzer pin.
//  50% duty square wave, one clock domain, no per-note modules.
// PARAMETERS
//  CNT_W   28      width of tone period counter (holds largest divisor, C4 = 382219)
//  MS_DIV  100000  clock_in cycles per 1 ms tick (100 MHz board clock)
//  DUR_W   16      width of duration field, in ms
//  OCT_W   2       octave field width; octave 0..3 = musical octave 4..7
// PORTS
//  clock_in   in   1      system clock, 100 MHz
//  reset      in   1      synchronous, active-high reset
//  start      in   1      request; accepted only when ready=1
//  note_sel   in   4      0=C .. 11=B; 12..15 = rest (silent, duration still counted)
//  octave     in   OCT_W  divisor shifted right by octave
//  dur_ms     in   DUR_W  note length in ms; 0 = finish immediately
//  stop       in   1      abort current note
//  ready      out  1      1 in IDLE
//  done       out  1      one-cycle pulse when duration elapses (not on stop/reset)
//  clock_out  out  1      tone output to buzzer
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, done=0, clock_out=0, all counters 0. Reset wins over
//   every other input, including mid-note.
//  FSM IDLE -> PLAY -> IDLE. IDLE: start=1 latches note_sel, octave, dur_ms; next cycle
//   state=PLAY, ready=0, tone counter=0, ms counter=0, ms remaining=dur_ms.
//  start while ready=0 is ignored (no queueing); inputs sampled only on acceptance.
//  Divisor = TABLE[note_sel] >> octave, fixed for the whole note (CNT_W bits).
//  Tone counter: counter <= counter+1; wraps to 0 when counter >= div-1.
//   clock_out <= (counter < div/2) registered: 1-cycle latency, high phase first.
//   First clock_out=1 appears 2 cycles after the start-accept edge.
//  Rest note (note_sel>=12): clock_out held 0, tone counter idle.
//  Duration: ms tick every MS_DIV cycles in PLAY; remaining decrements per tick;
//   tick that brings remaining to 0 -> done=1 for one cycle, state=IDLE, clock_out=0
//   the same cycle (note truncated mid-period, no extra half-cycle).
//  dur_ms=0: PLAY lasts one cycle, done pulses, back to IDLE; clock_out never rises.
//  stop in PLAY: next cycle IDLE, clock_out=0, done=0. stop in IDLE: no effect.
//  stop and duration expiry on same cycle: stop wins, no done.
//  start on the cycle done pulses is ignored (ready still 0); accepted from next cycle.
//  Arithmetic unsigned; div/2 truncates (odd divisors: high phase one cycle shorter).
// STRUCTURE
//  notes_pkg (shared include): NOTE_C..NOTE_B, NOTE_REST indices; 12-entry divisor table
//   for octave 4 at 100 MHz: C 382219, C# 360776, D 340530, D# 321408, E 303370,
//   F 286344, F# 270270, G 255102, G# 240790, A 227272, A# 214519, B 202478;
//   FSM state encodings IDLE=0, PLAY=1.
//  Sub-module ms_tick (clock_in, reset, en -> tick): MS_DIV counter, cleared when en=0.
//  Top holds FSM, latched fields, tone counter, duration counter.
// TESTING (MS_DIV overridden to 1000 for run time)
//  1 reset 5 cycles -> ready=1, done=0, clock_out=0; start held during reset ignored.
//  2 start note_sel=9 octave=0 dur_ms=2 -> clock_out period 227272? no: truncated at
//    2000 cycles: clock_out high from cycle 2 through end; done pulses once at 2001.
//    Repeat with MS_DIV=100000, dur_ms=3 -> high 113636 / low 113636 cycles, done once.
//  3 note_sel=0 octave=3 -> period 382219>>3 = 47777 cycles, high 23888 cycles.
//  4 note_sel=13 dur_ms=4 -> clock_out stays 0, done after 4000 cycles, ready=1 after.
//  5 stop mid-note, and reset mid-note -> IDLE next cycle, clock_out=0, no done pulse;
//    stop coincident with final tick -> no done.
//  6 dur_ms=0 -> done 1 cycle after accept; start during PLAY and on done cycle ignored.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared note indices, FSM state encoding and the octave-4 tone divisor table
// for a 100 MHz clock.
package note_player_pkg;

    localparam int DIV_W = 28;

    localparam logic [3:0] NOTE_C    = 4'd0;
    localparam logic [3:0] NOTE_CS   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_DS   = 4'd3;
    localparam logic [3:0] NOTE_E    = 4'd4;
    localparam logic [3:0] NOTE_F    = 4'd5;
    localparam logic [3:0] NOTE_FS   = 4'd6;
    localparam logic [3:0] NOTE_G    = 4'd7;
    localparam logic [3:0] NOTE_GS   = 4'd8;
    localparam logic [3:0] NOTE_A    = 4'd9;
    localparam logic [3:0] NOTE_AS   = 4'd10;
    localparam logic [3:0] NOTE_B    = 4'd11;
    localparam logic [3:0] NOTE_REST = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // Rest indices return 0; the caller keeps the tone path idle for them.
    function automatic logic [DIV_W-1:0] note_div(input logic [3:0] n);
        logic [DIV_W-1:0] d;
        d = '0;
        case (n)
            NOTE_C:  d = 28'd382219;
            NOTE_CS: d = 28'd360776;
            NOTE_D:  d = 28'd340530;
            NOTE_DS: d = 28'd321408;
            NOTE_E:  d = 28'd303370;
            NOTE_F:  d = 28'd286344;
            NOTE_FS: d = 28'd270270;
            NOTE_G:  d = 28'd255102;
            NOTE_GS: d = 28'd240790;
            NOTE_A:  d = 28'd227272;
            NOTE_AS: d = 28'd214519;
            NOTE_B:  d = 28'd202478;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/note_player_ms_tick.sv
// Millisecond strobe: one-cycle tick every MS_DIV enabled cycles, counter
// cleared whenever the enable drops.
module note_player_ms_tick #(
    parameter int MS_DIV = 100000
) (
    input  logic clock_in,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(MS_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock_in) begin
        if (reset || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/note_player.sv
// Square-wave note player: plays one semitone/octave for dur_ms milliseconds
// behind a start/ready handshake and pulses done when the duration elapses.
module note_player
    import note_player_pkg::*;
#(
    parameter int CNT_W  = 28,
    parameter int MS_DIV = 100000,
    parameter int DUR_W  = 16,
    parameter int OCT_W  = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       note_sel,
    input  logic [OCT_W-1:0] octave,
    input  logic [DUR_W-1:0] dur_ms,
    input  logic             stop,
    output logic             ready,
    output logic             done,
    output logic             clock_out
);
    state_e           r_state;
    logic             r_ready;
    logic             r_done;
    logic             r_clk;
    logic             r_rest;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [DUR_W-1:0] r_remain;

    logic w_tick;
    logic w_finish;

    note_player_ms_tick #(.MS_DIV(MS_DIV)) u_ms_tick (
        .clock_in (clock_in),
        .reset    (reset),
        .en       (r_state == ST_PLAY),
        .tick     (w_tick)
    );

    // Zero remaining covers dur_ms=0; otherwise finish on the tick that empties it.
    assign w_finish = (r_remain == '0) || (w_tick && (r_remain == DUR_W'(1)));

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_clk    <= 1'b0;
            r_rest   <= 1'b0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_remain <= '0;
        end else if (r_state == ST_IDLE) begin
            r_done <= 1'b0;
            r_clk  <= 1'b0;
            if (start && r_ready) begin
                r_state  <= ST_PLAY;
                r_ready  <= 1'b0;
                r_rest   <= (note_sel >= NOTE_REST);
                r_div    <= CNT_W'(note_div(note_sel) >> octave);
                r_cnt    <= '0;
                r_remain <= dur_ms;
            end else begin
                r_ready <= 1'b1;
            end
        end else begin
            if (stop) begin
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
                r_clk   <= 1'b0;
            end else if (w_finish) begin
                // ready stays low for the done cycle so a start there is ignored.
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
                r_clk   <= 1'b0;
            end else begin
                if (w_tick) begin
                    r_remain <= r_remain - 1'b1;
                end
                if (!r_rest) begin
                    r_clk <= (r_cnt < (r_div >> 1));
                    r_cnt <= (r_cnt >= r_div - 1'b1) ? '0 : r_cnt + 1'b1;
                end
            end
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign clock_out = r_clk;

endmodule
